// File: rtl/usb_spi_target_pkg.sv
// Shared opcodes and frame-decoder state encoding for the USB-to-SPI bridge target.
package usb_spi_target_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_ID     = 8'h9F;
    localparam logic [7:0] OP_STATUS = 8'h05;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RESP,
        ST_SINK,
        ST_DATA
    } spi_state_t;

endpackage

// File: rtl/usb_spi_target_spi_pin_sync.sv
// Two-flop synchronizer for an idle-high SPI pin, with registered rise/fall pulses
// that appear 3 clk after the pin edge.
module spi_pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            prev   <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= pin;
            sync_q <= meta;
            prev   <= sync_q;
            rise   <= sync_q & ~prev;
            fall   <= ~sync_q & prev;
        end
    end

    assign sync = sync_q;

endmodule

// File: rtl/usb_spi_target.sv
// Mode-3 SPI target servicing WRITE/READ/ID/STATUS frames against a 32x8 buffer
// that a local fabric port also reads and writes.
module usb_spi_target
    import usb_spi_target_pkg::*;
#(
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       loc_wr_en,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wr_data,
    output logic [7:0] loc_rd_data,
    output logic       cmd_done,
    output logic [7:0] last_cmd
);

    logic       sck_sync, sck_rise, sck_fall;
    logic       csn_sync, csn_rise, csn_fall;
    logic       mosi_meta, mosi_sync;
    spi_state_t state, state_next;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic [7:0] tx_next;
    logic [4:0] addr;
    logic [4:0] addr_inc;
    logic [4:0] wr_count;
    logic       got_byte;
    logic       miso_q;
    logic       spi_we;
    logic       frame_live, bit_edge, shift_edge, byte_done;
    logic [7:0] mem [32];

    spi_pin_sync u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_clk),
        .sync  (sck_sync),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_pin_sync u_csn_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_csn),
        .sync  (csn_sync),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_meta <= 1'b1;
            mosi_sync <= 1'b1;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // An edge pulse only counts if the synchronized level still agrees, so SCK
    // glitches narrower than a clk never shift a bit.
    assign frame_live = (state != ST_IDLE) && !csn_rise;
    assign bit_edge   = frame_live && sck_rise && sck_sync;
    assign shift_edge = frame_live && sck_fall && !sck_sync;
    assign byte_done  = bit_edge && (bit_cnt == 3'd7);
    assign rx_byte    = {rx_shift, mosi_sync};
    assign addr_inc   = addr + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state != ST_IDLE && csn_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (csn_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            OP_WRITE, OP_READ: state_next = ST_ADDR;
                            OP_ID, OP_STATUS:  state_next = ST_RESP;
                            default:           state_next = ST_SINK;
                        endcase
                    end
                end
                ST_ADDR: if (byte_done) state_next = ST_DATA;
                default: state_next = state;
            endcase
        end
    end

    // Response byte loaded at the end of the current byte, shifted out on the next one.
    always_comb begin
        tx_next = IDLE_BYTE;
        spi_we  = 1'b0;
        case (state)
            ST_CMD: begin
                if (rx_byte == OP_ID)          tx_next = ID_BYTE;
                else if (rx_byte == OP_STATUS) tx_next = {3'b000, wr_count};
            end
            ST_ADDR: if (last_cmd == OP_READ) tx_next = mem[rx_byte[4:0]];
            ST_RESP: tx_next = (last_cmd == OP_ID) ? ID_BYTE : {3'b000, wr_count};
            ST_DATA: begin
                if (last_cmd == OP_READ)       tx_next = mem[addr_inc];
                else if (last_cmd == OP_WRITE) spi_we  = byte_done;
            end
            default: tx_next = IDLE_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= IDLE_BYTE;
            miso_q      <= 1'b1;
            addr        <= 5'd0;
            wr_count    <= 5'd0;
            last_cmd    <= 8'h00;
            got_byte    <= 1'b0;
            loc_rd_data <= 8'h00;
        end else begin
            loc_rd_data <= mem[loc_addr];
            if (csn_fall || csn_rise) begin
                bit_cnt  <= 3'd0;
                got_byte <= 1'b0;
                tx_shift <= IDLE_BYTE;
                miso_q   <= 1'b1;
            end else begin
                if (bit_edge) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    got_byte <= 1'b1;
                    tx_shift <= tx_next;
                    case (state)
                        ST_CMD: begin
                            last_cmd <= rx_byte;
                            if (rx_byte == OP_WRITE) wr_count <= 5'd0;
                        end
                        ST_ADDR: addr <= rx_byte[4:0];
                        ST_DATA: begin
                            addr <= addr_inc;
                            if (last_cmd == OP_WRITE && wr_count != 5'd31)
                                wr_count <= wr_count + 5'd1;
                        end
                        default: addr <= addr;
                    endcase
                end
                if (shift_edge) begin
                    miso_q   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b1};
                end
            end
        end
    end

    // SPI write port has priority; a coincident local write is dropped.
    always_ff @(posedge clk) begin
        if (spi_we)         mem[addr]     <= rx_byte;
        else if (loc_wr_en) mem[loc_addr] <= loc_wr_data;
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~csn_sync;
    assign cmd_done    = csn_rise & got_byte;

endmodule

// File: tb/tb_usb_spi_target.sv
// Bench for usb_spi_target: bit-banged SPI master at SCK = clk/8 and a frame-level
// reference model of the buffer, opcode responses and write counter.
module tb_usb_spi_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_clk = 1'b1;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b1;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       loc_wr_en = 1'b0;
    logic [4:0] loc_addr = 5'd0;
    logic [7:0] loc_wr_data = 8'h00;
    logic [7:0] loc_rd_data;
    logic       cmd_done;
    logic [7:0] last_cmd;

    always #5 clk = ~clk;

    usb_spi_target #(.ID_BYTE(8'hA5)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .loc_wr_en   (loc_wr_en),
        .loc_addr    (loc_addr),
        .loc_wr_data (loc_wr_data),
        .loc_rd_data (loc_rd_data),
        .cmd_done    (cmd_done),
        .last_cmd    (last_cmd)
    );

    int n_checks = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] mem_m [32];
    logic [4:0] wrc_m = 5'd0;
    logic [7:0] last_m = 8'h00;
    logic [7:0] fb[$];
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected MISO byte for position i of the frame in fb, from the opcode rules.
    function automatic logic [7:0] exp_byte(input int i);
        logic [4:0] a;
        if (i == 0) return 8'hFF;
        case (fb[0])
            8'h02: return 8'hFF;
            8'h03: begin
                if (i == 1) return 8'hFF;
                a = fb[1][4:0] + 5'(i - 2);
                return mem_m[a];
            end
            8'h9F: return 8'hA5;
            8'h05: return {3'b000, wrc_m};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_commit(input int nfull);
        logic [4:0] a;
        if (nfull >= 1) last_m = fb[0];
        if (nfull >= 1 && fb[0] == 8'h02) begin
            wrc_m = 5'd0;
            for (int i = 2; i < nfull; i++) begin
                a = fb[1][4:0] + 5'(i - 2);
                mem_m[a] = fb[i];
                if (wrc_m != 5'd31) wrc_m = wrc_m + 5'd1;
            end
        end
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_wr_en = 1'b1; loc_addr = a; loc_wr_data = d;
        @(negedge clk);
        loc_wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        loc_addr = a;
        @(negedge clk);
        d = loc_rd_data;
    endtask

    task automatic loc_check(input logic [4:0] a);
        logic [7:0] d;
        loc_read(a, d);
        check_eq($sformatf("loc_rd[%0d]", a), d, mem_m[a]);
    endtask

    task automatic spi_start();
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Shifts out the top nbits of b; MISO is sampled as SCK rises. With collide set,
    // a local write to addr 7 is placed on the exact clk the last bit commits.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r,
                            input bit collide);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            spi_clk = 1'b0; spi_mosi = b[i]; loc_wr_en = 1'b0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            spi_clk = 1'b1;
            r[i] = spi_miso;
            repeat (3) @(negedge clk);
            if (collide && i == 0) begin
                loc_wr_en = 1'b1; loc_addr = 5'd7; loc_wr_data = 8'h99;
            end
        end
    endtask

    task automatic spi_end(input bit exp_done);
        @(negedge clk);
        loc_wr_en = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("done_early", 8'(cmd_done), 8'h00);
        @(negedge clk);
        check_eq("cmd_done", 8'(cmd_done), 8'(exp_done));
        @(negedge clk);
        check_eq("done_width", 8'(cmd_done), 8'h00);
        check_eq("oe_idle", 8'(spi_miso_oe), 8'h00);
        check_eq("miso_idle", 8'(spi_miso), 8'h01);
        repeat (4) @(negedge clk);
    endtask

    // Runs fb as one frame: nfull complete bytes, then extra bits of a partial byte.
    task automatic run_frame(input int nfull, input int extra, input bit collide);
        logic [7:0] r;
        exp_q.delete();
        for (int i = 0; i < nfull; i++) exp_q.push_back(exp_byte(i));
        spi_start();
        check_eq("oe_active", 8'(spi_miso_oe), 8'h01);
        check_eq("miso_cs", 8'(spi_miso), 8'h01);
        for (int i = 0; i < nfull; i++) begin
            spi_bits(fb[i], 8, r, collide && extra == 0 && i == nfull - 1);
            check_eq($sformatf("miso[%0d] op=%h", i, fb[0]), r, exp_q.pop_front());
        end
        if (extra > 0) spi_bits(fb[nfull], extra, r, 1'b0);
        spi_end(nfull > 0);
        model_commit(nfull);
        check_eq("last_cmd", last_cmd, last_m);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] op;
        int k, nfull, extra, total;

        repeat (4) @(negedge clk);
        check_eq("rst_miso", 8'(spi_miso), 8'h01);
        check_eq("rst_oe", 8'(spi_miso_oe), 8'h00);
        check_eq("rst_loc_rd", loc_rd_data, 8'h00);
        check_eq("rst_cmd_done", 8'(cmd_done), 8'h00);
        check_eq("rst_last_cmd", last_cmd, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int a = 0; a < 32; a++) loc_write(5'(a), 8'($urandom));

        // WRITE wrapping past the top of the buffer, then STATUS.
        fb = '{8'h02, 8'h1E, 8'hAA, 8'hBB, 8'hCC};
        run_frame(5, 0, 1'b0);
        loc_read(5'd30, d); check_eq("wr_mem30", d, 8'hAA);
        loc_read(5'd31, d); check_eq("wr_mem31", d, 8'hBB);
        loc_read(5'd0, d);  check_eq("wr_mem0", d, 8'hCC);
        fb = '{8'h05, 8'h00};
        run_frame(2, 0, 1'b0);

        loc_write(5'd5, 8'h5A);
        loc_write(5'd6, 8'hC3);
        fb = '{8'h03, 8'h05, 8'h00, 8'h00};
        run_frame(4, 0, 1'b0);

        fb = '{8'h9F, 8'h00, 8'h00};
        run_frame(3, 0, 1'b0);

        // CS raised 4 bits into the data byte; the next frame must decode cleanly.
        fb = '{8'h02, 8'h04, 8'h77};
        run_frame(2, 4, 1'b0);
        loc_check(5'd4);
        fb = '{8'h9F, 8'h00};
        run_frame(2, 0, 1'b0);

        fb = '{8'h02, 8'h07, 8'h11};
        run_frame(3, 0, 1'b1);
        loc_read(5'd7, d); check_eq("collide_mem7", d, 8'h11);

        // Reset in the middle of a READ data byte.
        spi_start();
        spi_bits(8'h03, 8, r, 1'b0);
        spi_bits(8'h05, 8, r, 1'b0);
        spi_bits(8'h00, 5, r, 1'b0);
        @(negedge clk);
        reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b1;
        @(negedge clk);
        check_eq("midrst_miso", 8'(spi_miso), 8'h01);
        check_eq("midrst_oe", 8'(spi_miso_oe), 8'h00);
        check_eq("midrst_last_cmd", last_cmd, 8'h00);
        last_m = 8'h00;
        wrc_m = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        fb = '{8'h03, 8'h05, 8'h00, 8'h00};
        run_frame(4, 0, 1'b0);
        fb = '{8'h05, 8'h00};
        run_frame(2, 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: op = 8'h02;
                1: op = 8'h03;
                2: op = 8'h9F;
                3: op = 8'h05;
                default: op = 8'($urandom);
            endcase
            nfull = $urandom_range(1, 6);
            extra = 0;
            if ($urandom_range(0, 4) == 0) begin
                extra = $urandom_range(1, 7);
                nfull = $urandom_range(0, 5);
            end
            total = nfull + ((extra > 0) ? 1 : 0);
            fb.delete();
            fb.push_back(op);
            for (int i = 1; i < total; i++) fb.push_back(8'($urandom));
            run_frame(nfull, extra, 1'b0);
            if ($urandom_range(0, 2) == 0) loc_write(5'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) loc_check(5'($urandom));
        end

        for (int a = 0; a < 32; a++) loc_check(5'(a));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
